seq_div_unit: RTL and testbench

SEQ_DIV_UNIT -- requirements
Module: seq_div_unit

---
 rtl/seq_div_unit.sv | 145 ++++++++++++++
 tb/tb_seq_div_unit.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/seq_div_unit.sv
// rtl/seq_div_unit.sv - iterative restoring divider, signed/unsigned, one quotient bit per cycle
module seq_div_unit #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic             op_signed,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] remainder
);

   localparam int CW = $clog2(WIDTH + 1);
   localparam logic [WIDTH-1:0] ZERO = '0;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t state_q, state_d;

   logic [CW-1:0]    cnt_q, cnt_d;
   // partial remainder carries one extra bit so the trial subtract exposes its borrow
   logic [WIDTH:0]   prem_q, prem_d;
   // dividend magnitude shifts out MSB first while quotient bits shift in at the LSB
   logic [WIDTH-1:0] acc_q, acc_d;
   logic [WIDTH-1:0] dvs_q, dvs_d;
   logic             neg_quo_q, neg_quo_d;
   logic             neg_rem_q, neg_rem_d;
   logic [WIDTH-1:0] quotient_q, quotient_d;
   logic [WIDTH-1:0] remainder_q, remainder_d;

   logic             dvd_neg, dvs_neg;
   logic [WIDTH-1:0] dvd_mag, dvs_mag;
   logic [WIDTH:0]   shifted, diff, next_rem;
   logic             qbit;
   logic [WIDTH-1:0] next_acc;

   // state register
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // datapath and result registers
   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_q       <= '0;
         prem_q      <= '0;
         acc_q       <= '0;
         dvs_q       <= '0;
         neg_quo_q   <= 1'b0;
         neg_rem_q   <= 1'b0;
         quotient_q  <= '0;
         remainder_q <= '0;
      end else begin
         cnt_q       <= cnt_d;
         prem_q      <= prem_d;
         acc_q       <= acc_d;
         dvs_q       <= dvs_d;
         neg_quo_q   <= neg_quo_d;
         neg_rem_q   <= neg_rem_d;
         quotient_q  <= quotient_d;
         remainder_q <= remainder_d;
      end
   end

   // next-state, one restoring step, operand capture and result formation
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      prem_d      = prem_q;
      acc_d       = acc_q;
      dvs_d       = dvs_q;
      neg_quo_d   = neg_quo_q;
      neg_rem_d   = neg_rem_q;
      quotient_d  = quotient_q;
      remainder_d = remainder_q;

      busy = (state_q == CALC);
      done = (state_q == DONE);

      dvd_neg = op_signed & dividend[WIDTH-1];
      dvs_neg = op_signed & divisor[WIDTH-1];
      dvd_mag = dvd_neg ? (ZERO - dividend) : dividend;
      dvs_mag = dvs_neg ? (ZERO - divisor) : divisor;

      // remainder is always below the divisor, so shifting left never loses a set bit
      shifted  = (prem_q << 1) | {{WIDTH{1'b0}}, acc_q[WIDTH-1]};
      diff     = shifted - {1'b0, dvs_q};
      qbit     = ~diff[WIDTH];
      next_rem = qbit ? diff : shifted;
      next_acc = {acc_q[WIDTH-2:0], qbit};

      case (state_q)
         IDLE, DONE: begin
            if (state_q == DONE) begin
               state_d = IDLE;
            end
            if (start) begin
               cnt_d = CW'(WIDTH);
               if (divisor == ZERO) begin
                  // divide-by-zero skips iteration; remainder is the raw dividend in both modes
                  state_d     = DONE;
                  quotient_d  = '1;
                  remainder_d = dividend;
               end else begin
                  state_d   = CALC;
                  prem_d    = '0;
                  acc_d     = dvd_mag;
                  dvs_d     = dvs_mag;
                  neg_quo_d = dvd_neg ^ dvs_neg;
                  neg_rem_d = dvd_neg;
               end
            end
         end
         CALC: begin
            prem_d = next_rem;
            acc_d  = next_acc;
            cnt_d  = cnt_q - CW'(1);
            if (cnt_q == CW'(1)) begin
               state_d     = DONE;
               quotient_d  = neg_quo_q ? (ZERO - next_acc) : next_acc;
               remainder_d = neg_rem_q ? (ZERO - next_rem[WIDTH-1:0]) : next_rem[WIDTH-1:0];
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   assign quotient  = quotient_q;
   assign remainder = remainder_q;

endmodule

// File: tb/tb_seq_div_unit.sv
// tb/tb_seq_div_unit.sv - scoreboard bench for seq_div_unit at WIDTH=32
module tb_seq_div_unit;

   logic        clk;
   logic        reset;
   logic        start;
   logic        op_signed;
   logic [31:0] dividend;
   logic [31:0] divisor;
   logic        busy;
   logic        done;
   logic [31:0] quotient;
   logic [31:0] remainder;

   seq_div_unit #(.WIDTH(32)) dut (
      .clk       (clk),
      .reset     (reset),
      .start     (start),
      .op_signed (op_signed),
      .dividend  (dividend),
      .divisor   (divisor),
      .busy      (busy),
      .done      (done),
      .quotient  (quotient),
      .remainder (remainder)
   );

   typedef struct {
      int          cyc;
      logic [31:0] q;
      logic [31:0] r;
   } exp_t;

   exp_t sb[$];
   int   cyc   = 0;
   int   n_cmp = 0;
   int   n_bad = 0;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%08h want 0x%08h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // monitor: every done pulse must match the oldest outstanding expectation
   always @(negedge clk) begin
      if (done) begin
         if (sb.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL unexpected_done: got done=1 want no pending result (cycle %0d)", cyc);
         end else begin
            exp_t e;
            e = sb.pop_front();
            check("done_cycle", 32'(cyc), 32'(e.cyc));
            check("quotient", quotient, e.q);
            check("remainder", remainder, e.r);
         end
      end
   end

   task automatic issue(input logic rel, input logic sgn, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] qx, input logic [31:0] rx);
      @(negedge clk);
      if (rel) reset = 1'b0;
      op_signed = sgn;
      dividend  = a;
      divisor   = b;
      start     = 1'b1;
      sb.push_back('{cyc + 1 + ((b == 32'd0) ? 0 : 32), qx, rx});
      @(negedge clk);
      start     = 1'b0;
      dividend  = $urandom;
      divisor   = $urandom;
      op_signed = 1'($urandom);
   endtask

   task automatic wait_idle();
      for (int i = 0; i < 80 && sb.size() != 0; i++) @(negedge clk);
      check("drain_queue", 32'(sb.size()), 32'd0);
      @(negedge clk);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      reset     = 1'b1;
      start     = 1'b0;
      op_signed = 1'b0;
      dividend  = '0;
      divisor   = '0;
      repeat (3) @(negedge clk);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_quotient", quotient, 32'd0);
      check("rst_remainder", remainder, 32'd0);

      // start in the first cycle after reset release
      issue(1'b1, 1'b0, 32'd100, 32'd7, 32'd14, 32'd2);
      check("calc_busy", 32'(busy), 32'd1);
      check("calc_hold_q", quotient, 32'd0);
      repeat (10) @(negedge clk);
      check("calc_busy_mid", 32'(busy), 32'd1);
      wait_idle();
      check("idle_busy", 32'(busy), 32'd0);

      issue(1'b0, 1'b1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF);
      wait_idle();
      issue(1'b0, 1'b0, 32'hFFFF_FFF9, 32'd2, 32'h7FFF_FFFC, 32'd1);
      wait_idle();

      issue(1'b0, 1'b0, 32'd5, 32'd0, 32'hFFFF_FFFF, 32'd5);
      check("dz_busy_u", 32'(busy), 32'd0);
      wait_idle();
      issue(1'b0, 1'b1, 32'd5, 32'd0, 32'hFFFF_FFFF, 32'd5);
      check("dz_busy_s", 32'(busy), 32'd0);
      wait_idle();
      issue(1'b0, 1'b1, 32'h8000_0000, 32'd0, 32'hFFFF_FFFF, 32'h8000_0000);
      wait_idle();

      issue(1'b0, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0);
      wait_idle();
      issue(1'b0, 1'b0, 32'd0, 32'd7, 32'd0, 32'd0);
      wait_idle();
      issue(1'b0, 1'b1, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd1);
      wait_idle();
      issue(1'b0, 1'b1, 32'hFFFF_FFF9, 32'hFFFF_FFFE, 32'd3, 32'hFFFF_FFFF);
      wait_idle();

      // abandon an operation: ignored start mid-CALC, then reset
      issue(1'b0, 1'b0, 32'd100, 32'd7, 32'd14, 32'd2);
      repeat (9) @(negedge clk);
      op_signed = 1'b0;
      dividend  = 32'd9;
      divisor   = 32'd3;
      start     = 1'b1;
      @(negedge clk);
      start = 1'b0;
      check("ign_busy", 32'(busy), 32'd1);
      check("ign_hold_q", quotient, 32'd3);
      repeat (9) @(negedge clk);
      reset = 1'b1;
      sb.delete();
      @(negedge clk);
      check("abort_busy", 32'(busy), 32'd0);
      check("abort_done", 32'(done), 32'd0);
      check("abort_quotient", quotient, 32'd0);
      check("abort_remainder", remainder, 32'd0);
      reset = 1'b0;
      repeat (40) @(negedge clk);
      issue(1'b0, 1'b0, 32'd9, 32'd3, 32'd3, 32'd0);
      wait_idle();

      // back-to-back: start lands in the DONE cycle of the previous operation
      issue(1'b0, 1'b0, 32'd100, 32'd7, 32'd14, 32'd2);
      begin
         bit seen;
         seen = 1'b0;
         for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done) begin
               seen = 1'b1;
               break;
            end
         end
         check("b2b_first_done", 32'(seen), 32'd1);
      end
      op_signed = 1'b0;
      dividend  = 32'd50;
      divisor   = 32'd5;
      start     = 1'b1;
      sb.push_back('{cyc + 1 + 32, 32'd10, 32'd0});
      @(negedge clk);
      start    = 1'b0;
      dividend = $urandom;
      divisor  = $urandom;
      check("b2b_done_drop", 32'(done), 32'd0);
      check("b2b_hold_q", quotient, 32'd14);
      repeat (15) @(negedge clk);
      check("b2b_hold_r", remainder, 32'd2);
      wait_idle();

      check("final_queue", 32'(sb.size()), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
